// File: rtl/iob_cache_front_end_q.sv
// iob_cache_front_end_q: queued IOb front end that splits requests into cache-memory and control ports.
// Define IOB_CACHE_FE_STATS_EN to add rd_cnt_o/wr_cnt_o pop counters.
module iob_cache_front_end_q #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH = 4,
  parameter int USE_CTRL = 0,
  parameter int IOB_CACHE_SWREG_ADDR_W = 5
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              cke_i,
  input  logic                              iob_avalid_i,
  input  logic [ADDR_W-1:0]                 iob_addr_i,
  input  logic [DATA_W-1:0]                 iob_wdata_i,
  input  logic [DATA_W/8-1:0]               iob_wstrb_i,
  input  logic [3:0]                        iob_acache_i,
  output logic                              iob_ready_o,
  output logic                              iob_rvalid_o,
  output logic [DATA_W-1:0]                 iob_rdata_o,
  output logic                              data_req_o,
  output logic [ADDR_W-USE_CTRL-1:0]        data_addr_o,
  output logic [DATA_W-1:0]                 data_wdata_o,
  output logic [DATA_W/8-1:0]               data_wstrb_o,
  output logic [3:0]                        data_acache_o,
  input  logic [DATA_W-1:0]                 data_rdata_i,
  input  logic                              data_ack_i,
  output logic                              ctrl_req_o,
  output logic [IOB_CACHE_SWREG_ADDR_W-1:0] ctrl_addr_o,
  input  logic [DATA_W-1:0]                 ctrl_rdata_i,
  input  logic                              ctrl_ack_i,
  output logic [$clog2(DEPTH):0]            occupancy_o
`ifdef IOB_CACHE_FE_STATS_EN
  ,
  output logic [31:0]                       rd_cnt_o,
  output logic [31:0]                       wr_cnt_o
`endif
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  logic [ADDR_W-1:0]   addr_q   [DEPTH];
  logic [DATA_W-1:0]   wdata_q  [DEPTH];
  logic [DATA_W/8-1:0] wstrb_q  [DEPTH];
  logic [3:0]          acache_q [DEPTH];
  logic [DEPTH-1:0]    we_q, ctrl_q;
  logic [PTR_W-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [OCC_W-1:0]    occ_q, occ_d;
  logic non_empty, head_ctrl, push, pop;
  assign non_empty = occ_q != '0;
  assign head_ctrl = ctrl_q[rptr_q];
  // occupancy never exceeds DEPTH, so its MSB alone flags a full queue
  assign iob_ready_o = cke_i & ~occ_q[PTR_W];
  assign push = iob_avalid_i & iob_ready_o;
  assign pop = cke_i & ~rst_i & non_empty & (head_ctrl ? ctrl_ack_i : data_ack_i);
  assign iob_rvalid_o = pop & ~we_q[rptr_q];
  assign iob_rdata_o = head_ctrl ? ctrl_rdata_i : data_rdata_i;
  assign data_req_o = non_empty & ~head_ctrl;
  assign data_addr_o = addr_q[rptr_q][ADDR_W-USE_CTRL-1:0];
  assign data_wdata_o = wdata_q[rptr_q];
  assign data_wstrb_o = wstrb_q[rptr_q];
  assign data_acache_o = acache_q[rptr_q];
  assign ctrl_req_o = non_empty & head_ctrl;
  assign ctrl_addr_o = ctrl_req_o ? addr_q[rptr_q][IOB_CACHE_SWREG_ADDR_W-1:0] : '0;
  assign occupancy_o = occ_q;
  always_comb begin
    wptr_d = wptr_q + PTR_W'(push);
    rptr_d = rptr_q + PTR_W'(pop);
    occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q <= occ_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_q[wptr_q] <= iob_addr_i;
      wdata_q[wptr_q] <= iob_wdata_i;
      wstrb_q[wptr_q] <= iob_wstrb_i;
      acache_q[wptr_q] <= iob_acache_i;
      we_q[wptr_q] <= |iob_wstrb_i;
      ctrl_q[wptr_q] <= (USE_CTRL != 0) & iob_addr_i[ADDR_W-1];
    end
  end
`ifdef IOB_CACHE_FE_STATS_EN
  logic [31:0] rd_cnt_q, wr_cnt_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (pop & ~we_q[rptr_q]) rd_cnt_q <= rd_cnt_q + 32'd1;
      if (pop & we_q[rptr_q]) wr_cnt_q <= wr_cnt_q + 32'd1;
    end
  end
  assign rd_cnt_o = rd_cnt_q;
  assign wr_cnt_o = wr_cnt_q;
`endif
endmodule

// File: doc/iob_cache_front_end_q.md
IOB_CACHE_FRONT_END_Q -- requirements
Module: iob_cache_front_end_q

Interface
REQ-001 Parameter ADDR_W, default 32, meaning front-end byte address width.
REQ-002 Parameter DATA_W, default 32, meaning data width; a multiple of 8.
REQ-003 Parameter DEPTH, default 4, meaning request queue entries; a power of 2, at least 2.
REQ-004 Parameter USE_CTRL, default 0, meaning that when 1, address bit ADDR_W-1 selects the cache-control space.
REQ-005 Port clk_i, input, width 1, meaning the single clock; all logic on the rising edge.
REQ-006 Port rst_i, input, width 1, meaning the reset; synchronous, active-high.
REQ-007 Port cke_i, input, width 1, meaning clock enable; when low, no state changes.
REQ-008 Ports iob_avalid_i (1), iob_addr_i (ADDR_W), iob_wdata_i (DATA_W), iob_wstrb_i (DATA_W/8) and iob_acache_i (4) are inputs forming the IOb front-end request.
REQ-009 Ports iob_ready_o (1), iob_rvalid_o (1) and iob_rdata_o (DATA_W) are outputs forming the IOb front-end response.
REQ-010 Ports data_req_o (1), data_addr_o (ADDR_W-USE_CTRL), data_wdata_o (DATA_W), data_wstrb_o (DATA_W/8) and data_acache_o (4) are outputs forming the cache-memory request.
REQ-011 Ports data_rdata_i (DATA_W) and data_ack_i (1) are inputs forming the cache-memory response.
REQ-012 Ports ctrl_req_o (1) and ctrl_addr_o (IOB_CACHE_SWREG_ADDR_W) are outputs, and ctrl_rdata_i (DATA_W) and ctrl_ack_i (1) are inputs, forming the control interface.
REQ-013 Port occupancy_o, output, width clog2(DEPTH)+1, meaning the number of queued entries.

Function
REQ-014 The block SHALL accept (push) a request when iob_avalid_i, iob_ready_o and cke_i are all high.
REQ-015 iob_ready_o SHALL be registered-state derived: high iff occupancy < DEPTH and cke_i is high; a pop in the same cycle does not raise ready when the queue is full.
REQ-016 Each entry SHALL store addr, wdata, wstrb, acache, we = |wstrb, and ctrl = USE_CTRL & addr[ADDR_W-1].
REQ-017 The head entry SHALL drive data_* when occupancy > 0 and ctrl = 0, with data_req_o = 1.
REQ-018 The head entry SHALL drive ctrl_addr_o = addr[IOB_CACHE_SWREG_ADDR_W-1:0] with ctrl_req_o = 1 when ctrl = 1.
REQ-019 Minimum latency SHALL be one cycle: a request pushed in cycle N is presented no earlier than cycle N+1.
REQ-020 Head outputs SHALL remain stable until the matching ack (data_ack_i, or ctrl_ack_i for ctrl entries); the ack pops the head.
REQ-021 iob_rvalid_o SHALL equal the pop condition AND NOT head.we, in the same cycle as the ack.
REQ-022 iob_rdata_o SHALL be ctrl_rdata_i for a ctrl head and data_rdata_i otherwise.
REQ-023 Write acks SHALL pop without asserting rvalid.
REQ-024 Responses SHALL be strictly in order.
REQ-025 An ack for a request class that is not currently presented at the head SHALL be ignored.
REQ-026 With the queue empty, data_req_o, ctrl_req_o and iob_rvalid_o SHALL be 0.
REQ-027 A simultaneous push and pop SHALL leave occupancy unchanged.
REQ-028 The read and write pointers are clog2(DEPTH) bits and SHALL wrap modulo DEPTH.
REQ-029 With USE_CTRL = 0, ctrl_req_o SHALL be 0, ctrl_addr_o SHALL be 0, and the ctrl inputs SHALL be ignored.
REQ-030 While cke_i is low, pointers and occupancy SHALL hold, and acks SHALL be ignored.

Reset
REQ-031 On rst_i high at a clock edge, pointers and occupancy SHALL become 0, so iob_ready_o = 1 (given cke_i), and data_req_o = ctrl_req_o = iob_rvalid_o = 0.
REQ-032 Reset SHALL discard in-flight entries; acks arriving in the reset cycle SHALL be ignored.
REQ-033 Stored entry payloads need no reset.

Configuration
REQ-034 Macro IOB_CACHE_FE_STATS_EN, when defined, SHALL add outputs rd_cnt_o and wr_cnt_o, each 32 bits, reset to 0.
REQ-035 With IOB_CACHE_FE_STATS_EN defined, rd_cnt_o SHALL increment on each read pop and wr_cnt_o on each write pop, wrapping at 2^32; the counters SHALL also be cleared by rst_i.
REQ-036 Without IOB_CACHE_FE_STATS_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-037 Reset, then a single read to addr 0x100 with data_ack_i one cycle later and data_rdata_i = 0xDEADBEEF -> iob_rvalid_o pulses once with 0xDEADBEEF; occupancy returns to 0.
REQ-038 DEPTH = 4 with 5 back-to-back requests and no acks -> iob_ready_o falls after the 4th accept; the 5th is held until the first ack, with occupancy exactly 4.
REQ-039 Interleaved write (wstrb 0xF) then read, both acked -> one rvalid only, tied to the read; wr_cnt_o = 1 and rd_cnt_o = 1 with STATS_EN.
REQ-040 USE_CTRL = 1, read to addr 0x8000_0004 -> ctrl_req_o = 1, data_req_o = 0, ctrl_addr_o = 0x4; ctrl_ack_i with 0x12 -> rdata 0x12.
REQ-041 Continuous push and pop at full rate for 10 requests across a pointer wrap -> all rdata in issue order and occupancy steady at 1.
REQ-042 rst_i asserted with 3 entries queued -> next cycle occupancy = 0, data_req_o = 0, iob_ready_o = 1, and a late ack produces no rvalid.
